// File: rtl/seq_restoring_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
//   Shared definitions for the sequential restoring divider:
//     - div_state_e : controller states (idle / iterating / result pulse)
//     - cnt_w()     : width of the iteration counter for an N-bit divisor
// ---------------------------------------------------------------------------
package seq_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // The counter runs 0..N-1. Never return a zero width; N is at least 2,
    // but the guard keeps the function safe if it is reused elsewhere.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider_if
//   Operand / result bundle of the sequential restoring divider.
//   Ports (DATAWIDTH = N):
//     i_valid  operands valid                 (master -> slave)
//     A        2N-bit dividend                (master -> slave)
//     B        N-bit divisor                  (master -> slave)
//     i_ready  divider can accept             (slave -> master)
//     o_valid  one-cycle result pulse         (slave -> master)
//     Q        N-bit quotient                 (slave -> master)
//     R        N-bit remainder                (slave -> master)
//     o_err    divide-by-zero / overflow flag (slave -> master)
//   Modports: master = operand source, slave = divider.
// ---------------------------------------------------------------------------
interface seq_restoring_divider_if #(
    parameter int DATAWIDTH = 4
);

    logic                     i_valid;
    logic                     i_ready;
    logic [2*DATAWIDTH-1:0]   A;
    logic [DATAWIDTH-1:0]     B;
    logic                     o_valid;
    logic [DATAWIDTH-1:0]     Q;
    logic [DATAWIDTH-1:0]     R;
    logic                     o_err;

    modport master (
        output i_valid,
        output A,
        output B,
        input  i_ready,
        input  o_valid,
        input  Q,
        input  R,
        input  o_err
    );

    modport slave (
        input  i_valid,
        input  A,
        input  B,
        output i_ready,
        output o_valid,
        output Q,
        output R,
        output o_err
    );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// ---------------------------------------------------------------------------
// restoring_div_step
//   One combinational radix-2 restoring iteration.
//   Ports (DATAWIDTH = N):
//     pr        in  N+1  current partial remainder
//     next_bit  in  1    next dividend bit (MSB of the dividend shift register)
//     divisor   in  N    divisor
//     pr_next   out N+1  partial remainder after this iteration
//     q_bit     out 1    resolved quotient bit
//   The trial value is {pr[N-1:0], next_bit}; pr[N] is shifted out and
//   discarded. For in-range operands it is always zero, and for overflowing
//   operands dropping it gives the defined truncated result.
// ---------------------------------------------------------------------------
module restoring_div_step #(
    parameter int DATAWIDTH = 4
) (
    input  logic [DATAWIDTH:0]   pr,
    input  logic                 next_bit,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic [DATAWIDTH:0]   pr_next,
    output logic                 q_bit
);

    logic [DATAWIDTH:0]   shifted;
    logic [DATAWIDTH+1:0] diff;
    logic                 unused_pr_msb;

    assign unused_pr_msb = pr[DATAWIDTH];
    assign shifted       = {pr[DATAWIDTH-1:0], next_bit};

    // One extra MSB on the subtraction acts as the borrow: clear means the
    // trial difference is non-negative and is kept.
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~diff[DATAWIDTH+1];
    assign pr_next = q_bit ? diff[DATAWIDTH:0] : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//   Iterative radix-2 restoring divider: unsigned 2N-bit dividend divided by
//   an N-bit divisor gives an N-bit quotient and an N-bit remainder. One
//   quotient bit is resolved per clock; operands are taken with a
//   valid/ready handshake and the result is announced with a one-cycle
//   o_valid pulse N+1 cycles after the accept cycle.
//
//   Parameters:
//     DATAWIDTH    N (>= 2): divisor / quotient / remainder width
//     INSTANCE_ID  identification only, no functional effect
//   Ports:
//     clk   in  clock, all state on the rising edge
//     rst   in  asynchronous active-low reset (0 = reset)
//     bus   seq_restoring_divider_if.slave (i_valid/i_ready/A/B in,
//           o_valid/Q/R/o_err out)
//
//   Build option:
//     SEQ_DIV_RANGE_CHECK_EN  when defined, B == 0 or A[2N-1:N] >= B is
//       detected at accept; the iterations are skipped, the result pulse
//       follows immediately with Q = all ones, R = A[N-1:0], o_err = 1.
//       When undefined no compare logic exists and o_err is tied to 0.
// ---------------------------------------------------------------------------
module seq_restoring_divider
    import seq_div_pkg::*;
#(
    parameter int DATAWIDTH   = 4,
    parameter int INSTANCE_ID = 0
) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider_if.slave bus
);

    localparam int            CW                 = cnt_w(DATAWIDTH);
    localparam logic [CW-1:0] CNT_LAST           = CW'(DATAWIDTH - 1);
    localparam int            unused_instance_id = INSTANCE_ID;

    div_state_e             state;
    logic [CW-1:0]          cnt;
    logic [DATAWIDTH:0]     pr;
    logic [DATAWIDTH-1:0]   dvd;
    logic [DATAWIDTH-1:0]   quot;
    logic [DATAWIDTH-1:0]   divisor;
    logic [DATAWIDTH-1:0]   q_out;
    logic [DATAWIDTH-1:0]   r_out;

    logic [DATAWIDTH-1:0]   a_hi;
    logic [DATAWIDTH-1:0]   a_lo;
    logic [DATAWIDTH:0]     step_pr;
    logic                   step_q;
    logic [DATAWIDTH-1:0]   quot_next;

    assign a_hi = bus.A[2*DATAWIDTH-1:DATAWIDTH];
    assign a_lo = bus.A[DATAWIDTH-1:0];

    restoring_div_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .pr       (pr),
        .next_bit (dvd[DATAWIDTH-1]),
        .divisor  (divisor),
        .pr_next  (step_pr),
        .q_bit    (step_q)
    );

    // The first resolved bit is the quotient MSB; shifting each new bit in
    // at the LSB leaves it in place after N iterations.
    assign quot_next = (quot << 1) | {{(DATAWIDTH-1){1'b0}}, step_q};

`ifdef SEQ_DIV_RANGE_CHECK_EN
    logic err_out;
    logic range_err;

    // The quotient fits in N bits only when the dividend's upper half is
    // strictly below the divisor; this also covers B == 0.
    assign range_err = (bus.B == '0) || (a_hi >= bus.B);
`endif

    // Controller and datapath registers. Q/R (and o_err) are only loaded
    // on the way into DIV_DONE so they stay stable between result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            pr      <= '0;
            dvd     <= '0;
            quot    <= '0;
            divisor <= '0;
            q_out   <= '0;
            r_out   <= '0;
`ifdef SEQ_DIV_RANGE_CHECK_EN
            err_out <= 1'b0;
`endif
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (bus.i_valid) begin
                        divisor <= bus.B;
                        pr      <= {1'b0, a_hi};
                        dvd     <= a_lo;
                        quot    <= '0;
                        cnt     <= '0;
`ifdef SEQ_DIV_RANGE_CHECK_EN
                        if (range_err) begin
                            state   <= DIV_DONE;
                            q_out   <= '1;
                            r_out   <= a_lo;
                            err_out <= 1'b1;
                        end else begin
                            state   <= DIV_BUSY;
                        end
`else
                        state   <= DIV_BUSY;
`endif
                    end
                end

                DIV_BUSY: begin
                    pr   <= step_pr;
                    dvd  <= dvd << 1;
                    quot <= quot_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state   <= DIV_DONE;
                        q_out   <= quot_next;
                        r_out   <= step_pr[DATAWIDTH-1:0];
`ifdef SEQ_DIV_RANGE_CHECK_EN
                        err_out <= 1'b0;
`endif
                    end
                end

                DIV_DONE: begin
                    state <= DIV_IDLE;
                end

                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign bus.i_ready = (state == DIV_IDLE);
    assign bus.o_valid = (state == DIV_DONE);
    assign bus.Q       = q_out;
    assign bus.R       = r_out;

`ifdef SEQ_DIV_RANGE_CHECK_EN
    assign bus.o_err   = err_out;
`else
    assign bus.o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Directed self-checking bench for seq_restoring_divider (DATAWIDTH = 4).
//   Expected results are queued when operands are driven and popped when
//   the divider raises o_valid. Follows SEQ_DIV_RANGE_CHECK_EN if defined.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int DW = 4;

    typedef struct {
        string         tag;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_restoring_divider_if #(.DATAWIDTH(DW)) bus ();

    seq_restoring_divider #(
        .DATAWIDTH   (DW),
        .INSTANCE_ID (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference division as described for the datapath, written with plain
    // integers: the bit shifted past N is lost, a trial that fits is kept.
    function automatic void model(input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] q, output logic [DW-1:0] r,
                                  output logic err, output int off);
        int hi, lo, pr, s, qi;
        hi  = int'(a) >> DW;
        lo  = int'(a) % (1 << DW);
        pr  = hi;
        qi  = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            s = ((pr % (1 << DW)) * 2) + ((lo >> i) & 1);
            if (s >= int'(b)) begin
                pr = s - int'(b);
                qi = qi * 2 + 1;
            end else begin
                pr = s;
                qi = qi * 2;
            end
        end
        q   = DW'(qi);
        r   = DW'(pr % (1 << DW));
        err = 1'b0;
        off = DW + 1;
`ifdef SEQ_DIV_RANGE_CHECK_EN
        if (b == '0 || hi >= int'(b)) begin
            q   = '1;
            r   = DW'(lo);
            err = 1'b1;
            off = 1;
        end
`endif
    endfunction

    // Waits (bounded) for i_ready, presents operands for exactly one accept
    // edge, then scrambles A/B to show they are not re-sampled.
    task automatic apply_stimulus(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
        int waited = 0;
        @(negedge clk);
        while (!bus.i_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("accept_ready", 32'(bus.i_ready), 32'd1);
        bus.A       = a;
        bus.B       = b;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.A       = 8'($urandom);
        bus.B       = 4'($urandom);
    endtask

    // Drives one operation and follows it cycle by cycle: i_ready low until
    // the result cycle has passed, o_valid only in cycle accept+eoff.
    task automatic run_op(input string tag, input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic eerr,
                          input int eoff, input bit intrude);
        exp_t e;
        e.tag = tag;
        e.q   = eq;
        e.r   = er;
        e.err = eerr;
        sb.push_back(e);
        apply_stimulus(a, b);
        for (int j = 1; j <= eoff + 1; j++) begin
            @(negedge clk);
            check_output({tag, "_ready"}, 32'(bus.i_ready), 32'(j > eoff));
            check_output({tag, "_valid"}, 32'(bus.o_valid), 32'(j == eoff));
            if (bus.o_valid && sb.size() > 0) begin
                e = sb.pop_front();
                check_output({e.tag, "_q"},   32'(bus.Q),     32'(e.q));
                check_output({e.tag, "_r"},   32'(bus.R),     32'(e.r));
                check_output({e.tag, "_err"}, 32'(bus.o_err), 32'(e.err));
            end
            if (intrude) begin
                if (j < eoff) begin
                    bus.i_valid = 1'b1;
                    bus.A       = 8'd9;
                    bus.B       = 4'd3;
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
        end
        check_output({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        logic [DW-1:0] mq, mr;
        logic          merr;
        int            moff;
        int            e3_off;
        logic          e3_err;

        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.A       = '0;
        bus.B       = '0;

        #12;
        $display("[TB] reset state");
        check_output("rst_ready", 32'(bus.i_ready), 32'd1);
        check_output("rst_valid", 32'(bus.o_valid), 32'd0);
        check_output("rst_q",     32'(bus.Q),       32'd0);
        check_output("rst_r",     32'(bus.R),       32'd0);
        check_output("rst_err",   32'(bus.o_err),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] basic divisions");
        run_op("t1_100_7", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, DW + 1, 1'b0);
        run_op("t2_e1_f",  8'hE1,  4'hF, 4'd15, 4'd0, 1'b0, DW + 1, 1'b0);

`ifdef SEQ_DIV_RANGE_CHECK_EN
        e3_err = 1'b1;
        e3_off = 1;
`else
        e3_err = 1'b0;
        e3_off = DW + 1;
`endif
        run_op("t3_div0", 8'h35, 4'd0, 4'hF, 4'h5, e3_err, e3_off, 1'b0);

        model(8'h80, 4'd3, mq, mr, merr, moff);
        run_op("t4_ovf", 8'h80, 4'd3, mq, mr, merr, moff, 1'b0);

        model(8'h4F, 4'd9, mq, mr, merr, moff);
        run_op("x_4f_9", 8'h4F, 4'd9, mq, mr, merr, moff, 1'b0);
        model(8'h0C, 4'd1, mq, mr, merr, moff);
        run_op("x_0c_1", 8'h0C, 4'd1, mq, mr, merr, moff, 1'b0);
        model(8'h00, 4'd5, mq, mr, merr, moff);
        run_op("x_00_5", 8'h00, 4'd5, mq, mr, merr, moff, 1'b0);

        $display("[TB] i_valid while busy");
        run_op("t5_50_6", 8'd50, 4'd6, 4'd8, 4'd2, 1'b0, DW + 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_output("t5_no_queued", 32'(bus.o_valid), 32'd0);
            check_output("t5_q_hold",    32'(bus.Q),       32'd8);
        end
        run_op("t5_9_3", 8'd9, 4'd3, 4'd3, 4'd0, 1'b0, DW + 1, 1'b0);

        $display("[TB] reset mid-operation");
        apply_stimulus(8'd100, 4'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("t6_valid", 32'(bus.o_valid), 32'd0);
        check_output("t6_q",     32'(bus.Q),       32'd0);
        check_output("t6_r",     32'(bus.R),       32'd0);
        check_output("t6_err",   32'(bus.o_err),   32'd0);
        check_output("t6_ready", 32'(bus.i_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("t6_no_valid", 32'(bus.o_valid), 32'd0);
        end
        model(8'hC7, 4'hD, mq, mr, merr, moff);
        run_op("t6_after", 8'hC7, 4'hD, mq, mr, merr, moff, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
